// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch state encoding and opcode field definitions
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Opcode field position shared with the instruction register
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 3;

  localparam logic [3:0] DEFAULT_HALT_OP = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_fetch_pc_reg.sv
// rtl/fetch_unit_fetch_pc_reg.sv - fetch program counter with load and increment
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        incr,
  output logic [15:0] pc
);

  // Load wins over increment; increment wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (incr) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer feeding the IR load side
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter logic [3:0]  HALT_OP  = DEFAULT_HALT_OP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        ir_write,
  output logic        busy
);

  fetch_state_t state, next_state;
  logic [15:0]  fetch_pc;
  logic         pc_load;
  logic [15:0]  pc_load_value;
  logic         pc_incr;
  logic         accept;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_fetch_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load),
    .load_value (pc_load_value),
    .incr       (pc_incr),
    .pc         (fetch_pc)
  );

  // Stall and redirect gate the request in the same cycle they appear
  assign mem_req  = (state == FETCH) && !stall && !redirect;
  assign mem_addr = fetch_pc;
  assign accept   = mem_req && mem_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    pc_load       = 1'b0;
    pc_load_value = RESET_PC;
    pc_incr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_load    = 1'b1;
          next_state = stall ? HOLD : FETCH;
        end
      end
      FETCH, HOLD: begin
        if (redirect) begin
          pc_load       = 1'b1;
          pc_load_value = redirect_pc;
          next_state    = stall ? HOLD : FETCH;
        end else if (accept) begin
          pc_incr    = 1'b1;
          next_state = (opcode_of(mem_rdata) == HALT_OP) ? IDLE : FETCH;
        end else if (stall) begin
          next_state = HOLD;
        end else begin
          next_state = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst     <= 16'h0000;
      inst_pc  <= 16'h0000;
      ir_write <= 1'b0;
    end else begin
      ir_write <= accept;
      if (accept) begin
        inst    <= mem_rdata;
        inst_pc <= fetch_pc;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch sequencer that drives the instruction register's load side. It owns the fetch program counter and issues 16-bit word reads to instruction memory over a req/ready handshake.
- Each returned word is presented on `inst` with a one-cycle `ir_write` strobe, together with the address it came from.
- It sits between instruction memory and the IR. The datapath controls it through `start`, `stall` and `redirect`.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: fetch address loaded by reset and by `start`.
- `PC_STEP`, 2: increment applied to the fetch PC after each accepted word.
- `HALT_OP`, 4'hF: opcode (`inst[3:0]`) that returns the block to IDLE after delivery.

Ports:
- `clk`, input, 1: the block's single clock.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: in IDLE, loads `RESET_PC` and begins fetching.
- `stall`, input, 1: suppresses new memory requests while high.
- `redirect`, input, 1: branch/jump. Replaces the fetch PC.
- `redirect_pc`, input, 16: target address, sampled when `redirect`=1.
- `mem_req`, output, 1: read request, held until `mem_ready`.
- `mem_addr`, output, 16: read address, equal to the fetch PC while `mem_req`=1.
- `mem_ready`, input, 1: `mem_rdata` is valid this cycle and the request completes.
- `mem_rdata`, input, 16: instruction word.
- `inst`, output, 16: last delivered instruction. Holds its value between strobes.
- `inst_pc`, output, 16: address of `inst`.
- `ir_write`, output, 1: one-cycle strobe, high for exactly one cycle per delivered word.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
States: IDLE, FETCH, HOLD.
- `mem_req` = (state==FETCH) && !`stall` && !`redirect`. This is combinational from the registered state.
- `mem_addr` = `fetch_pc`.

IDLE:
- `mem_req`=0.
- On `start`: `fetch_pc` <= `RESET_PC`; go to FETCH. If `stall` is also high, go to HOLD instead.
- `redirect` is ignored in IDLE.

FETCH:
- Accept condition: `mem_req` && `mem_ready`.
- On accept:
  - `inst` <= `mem_rdata`
  - `inst_pc` <= `fetch_pc`
  - `ir_write` <= 1
  - `fetch_pc` <= `fetch_pc` + `PC_STEP`, truncated to 16 bits (16'hFFFE + 2 wraps to 16'h0000).
  - If `mem_rdata[3:0]`==`HALT_OP`, go to IDLE. Otherwise stay in FETCH.
- If `stall`=1 and there is no accept, go to HOLD.

HOLD:
- `mem_req`=0.
- When `stall`=0, return to FETCH. The same `fetch_pc` is re-requested.

Priority in FETCH and HOLD, highest first:
1. `reset`
2. `redirect`: `fetch_pc` <= `redirect_pc`. A `mem_ready` arriving in the same cycle is discarded, so no `ir_write` is issued. Next state is FETCH, or HOLD if `stall`=1.
3. Accept
4. `stall`

Other rules:
- `ir_write` is cleared every cycle it is not set by an accept.
- A `mem_ready` arriving while `mem_req`=0 is ignored.

## Timing
Reset values (asynchronous, applied immediately):
- state=IDLE
- `fetch_pc`=`RESET_PC`
- `inst`=16'h0000
- `inst_pc`=16'h0000
- `ir_write`=0
- `busy`=0
- `mem_req`=0

Latency:
- `start` at edge N: `mem_req` is high in cycle N+1.
- Accept at edge M: `inst` and `ir_write` are visible after edge M.
- With zero-wait memory (`mem_ready` tied high), throughput is 1 instruction per cycle and `ir_write` stays high continuously.

Handshake and mid-operation events:
- While `mem_req`=1 and `mem_ready`=0, `mem_addr` is stable.
- When `stall` is raised mid-request, `mem_req` drops in the same cycle and the request restarts from scratch.
- Reset asserted mid-operation drops `mem_req` immediately. After release, the block waits in IDLE for `start`.

## Structure
- Shared package holds:
  - the state encoding: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2
  - the opcode field position [3:0] used by both the IR and this block
  - the default `HALT_OP`
- One sub-module, `fetch_pc_reg`. It holds `fetch_pc` with reset, load (start/redirect) and increment controls.
- The FSM and the output registers live in `fetch_unit`.

## Test plan
- Reset, then `start`. Zero-wait memory returns 16'h1234 and 16'h5678 at addresses 0 and 2 → two consecutive `ir_write` strobes; `inst_pc`=0 then 2.
- `mem_ready` delayed 3 cycles → `mem_addr` holds 16'h0004 for all 4 request cycles; a single `ir_write`.
- `redirect` with `redirect_pc`=16'h0100 coinciding with `mem_ready` → no `ir_write` that cycle; the next request uses address 16'h0100.
- `stall` held for 5 cycles in FETCH → `mem_req`=0 throughout; after release, the same address is re-requested and no word is skipped.
- Word 16'h000F fetched → `ir_write` strobes, then IDLE with `busy`=0 and no further requests. Fetching 16'hFFFE wraps `fetch_pc` to 16'h0000.
- `reset` asserted while waiting on `mem_ready` → `mem_req`=0 and all outputs at reset values with no clock edge.
